phase_counter_generator: RTL and testbench



---
 rtl/phase_counter_pkg.sv | 36 +++
 rtl/phase_counter_generator_tick_prescaler.sv | 45 ++++
 rtl/phase_counter_generator.sv | 182 ++++++++++++++++++
 tb/tb_phase_counter_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter_pkg
// Description : Shared types and constants for the phase counter generator:
//               FSM state encoding, triangle limits derived from the number
//               of fractional bits, and configuration reset defaults.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package phase_counter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Largest positive value of an (n_frac+1)-bit two's-complement phase.
    function automatic int phase_max(input int n_frac);
        return (1 << n_frac) - 1;
    endfunction

    // Triangle lower turning point: symmetric with the top, so the most
    // negative code is never produced.
    function automatic int phase_min_tri(input int n_frac);
        return -phase_max(n_frac);
    endfunction

    localparam int N_FRAC_DEF    = 7;
    localparam int PHASE_MAX     = phase_max(N_FRAC_DEF);
    localparam int PHASE_MIN_TRI = phase_min_tri(N_FRAC_DEF);

    localparam int STEP_RST  = 1;
    localparam int PRESC_RST = 0;

endpackage : phase_counter_pkg
`default_nettype wire

// File: rtl/phase_counter_generator_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Clock divider. Counts while running; when the count equals
//               the compare value it emits a tick and restarts from 0.
// Ports       : clk_i, rst_i (async, active-high)
//               run_i     - count enable; count is held at 0 when low
//               clear_i   - forces the count to 0 on the next edge
//               compare_i - tick period minus 1
//               tick_o    - combinational tick pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import phase_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] compare_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] r_count;
    logic             w_hit;

    assign w_hit  = (r_count == compare_i);
    // The tick is not gated by clear_i: a tick that coincides with the run
    // request being withdrawn must still complete.
    assign tick_o = run_i & w_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= WIDTH'(PRESC_RST);
        end else if (clear_i || !run_i || w_hit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/phase_counter_generator.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter_generator
// Description : Programmable signed phase ramp with per-sample strobe.
//               A prescaler divides clk_i; each tick advances the phase by
//               the active step. Step/prescaler are double-buffered and only
//               applied on entering RUN or on a wrap tick.
//               Optional macro TRIANGLE_MODE_EN adds mode_i and a
//               triangle (up/down) ramp; otherwise sawtooth only.
// Ports       : clk_i, rst_i (async, active-high), enable_i, step_i,
//               presc_i, cfg_load_strobe_i, phase_clear_i,
//               [mode_i], counter_value_o, next_counter_value_strobe_o,
//               wrap_o
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter_generator
    import phase_counter_pkg::*;
#(
    parameter int N_FRAC  = 7,
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [N_FRAC:0]    step_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               cfg_load_strobe_i,
    input  logic               phase_clear_i,
`ifdef TRIANGLE_MODE_EN
    input  logic               mode_i,
`endif
    output logic [N_FRAC:0]    counter_value_o,
    output logic               next_counter_value_strobe_o,
    output logic               wrap_o
);

    localparam int W = N_FRAC + 1;

    state_t             r_state;
    logic [W-1:0]       r_phase;
    logic [W-1:0]       r_act_step;
    logic [W-1:0]       r_pend_step;
    logic [PRESC_W-1:0] r_act_presc;
    logic [PRESC_W-1:0] r_pend_presc;
    logic               r_strobe;
    logic               r_wrap;

    logic               w_run;
    logic               w_presc_tick;
    logic               w_tick;
    logic               w_apply;
    logic [W-1:0]       w_saw;
    logic [W-1:0]       w_next_phase;
    logic               w_wrap;

    assign w_run = (r_state == ST_RUN);

    tick_prescaler #(
        .WIDTH (PRESC_W)
    ) u_tick_prescaler (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (w_run),
        .clear_i   (phase_clear_i | (w_run & ~enable_i)),
        .compare_i (r_act_presc),
        .tick_o    (w_presc_tick)
    );

    // A clear wins over a coincident tick: no strobe, no phase step.
    assign w_tick = w_presc_tick & ~phase_clear_i;

    // Sawtooth: modulo add; wrap is the positive-to-negative transition.
    assign w_saw = r_phase + r_act_step;

`ifdef TRIANGLE_MODE_EN
    localparam logic signed [W:0] C_MAX     = (W+1)'(phase_max(N_FRAC));
    localparam logic signed [W:0] C_MIN_TRI = (W+1)'(phase_min_tri(N_FRAC));

    logic              r_dir;       // 0 = counting up, 1 = counting down
    logic              r_act_mode;  // 0 = sawtooth, 1 = triangle
    logic              w_next_dir;
    logic signed [W:0] w_up;
    logic signed [W:0] w_dn;

    // One extra bit so crossings past either limit are visible.
    assign w_up = $signed({r_phase[W-1], r_phase}) + $signed({1'b0, r_act_step});
    assign w_dn = $signed({r_phase[W-1], r_phase}) - $signed({1'b0, r_act_step});

    always_comb begin
        w_next_phase = w_saw;
        w_wrap       = ~r_phase[W-1] & w_saw[W-1];
        w_next_dir   = r_dir;
        if (r_act_mode) begin
            w_wrap = 1'b0;
            if (!r_dir) begin
                if (w_up > C_MAX) begin
                    w_next_phase = C_MAX[W-1:0];
                    w_next_dir   = 1'b1;
                end else begin
                    w_next_phase = w_up[W-1:0];
                end
            end else begin
                if (w_dn < C_MIN_TRI) begin
                    w_next_phase = C_MIN_TRI[W-1:0];
                    w_next_dir   = 1'b0;
                    w_wrap       = 1'b1;
                end else begin
                    w_next_phase = w_dn[W-1:0];
                end
            end
        end
    end
`else
    assign w_next_phase = w_saw;
    assign w_wrap       = ~r_phase[W-1] & w_saw[W-1];
`endif

    assign w_apply = ((r_state == ST_IDLE) & enable_i) | (w_tick & w_wrap);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_act_step   <= W'(STEP_RST);
            r_pend_step  <= W'(STEP_RST);
            r_act_presc  <= PRESC_W'(PRESC_RST);
            r_pend_presc <= PRESC_W'(PRESC_RST);
            r_strobe     <= 1'b0;
            r_wrap       <= 1'b0;
`ifdef TRIANGLE_MODE_EN
            r_dir        <= 1'b0;
            r_act_mode   <= 1'b0;
`endif
        end else begin
            r_strobe <= w_tick;
            r_wrap   <= w_tick & w_wrap;

            case (r_state)
                ST_IDLE: if (enable_i)  r_state <= ST_RUN;
                ST_RUN:  if (!enable_i) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (cfg_load_strobe_i) begin
                r_pend_step  <= step_i;
                r_pend_presc <= presc_i;
            end

            // A load that lands exactly on an apply point bypasses pending.
            if (w_apply) begin
                r_act_step  <= cfg_load_strobe_i ? step_i  : r_pend_step;
                r_act_presc <= cfg_load_strobe_i ? presc_i : r_pend_presc;
            end

            if (phase_clear_i) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= w_next_phase;
            end

`ifdef TRIANGLE_MODE_EN
            if (phase_clear_i) begin
                r_dir <= 1'b0;
            end else if (w_tick) begin
                r_dir <= w_next_dir;
            end
            if (w_apply) begin
                r_act_mode <= mode_i;
                if (!mode_i) begin
                    r_dir <= 1'b0;
                end
            end
`endif
        end
    end

    assign counter_value_o             = r_phase;
    assign next_counter_value_strobe_o = r_strobe;
    assign wrap_o                      = r_wrap;

endmodule : phase_counter_generator
`default_nettype wire

// File: tb/tb_phase_counter_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_counter_generator
// Description : Directed self-checking bench for phase_counter_generator.
//               Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_counter_generator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [7:0]  step_i;
    logic [15:0] presc_i;
    logic        cfg_load_strobe_i;
    logic        phase_clear_i;
`ifdef TRIANGLE_MODE_EN
    logic        mode_i;
`endif
    logic [7:0]  counter_value_o;
    logic        next_counter_value_strobe_o;
    logic        wrap_o;

    int total = 0;
    int bad   = 0;

    phase_counter_generator #(
        .N_FRAC  (7),
        .PRESC_W (16)
    ) dut (
        .clk_i                       (clk_i),
        .rst_i                       (rst_i),
        .enable_i                    (enable_i),
        .step_i                      (step_i),
        .presc_i                     (presc_i),
        .cfg_load_strobe_i           (cfg_load_strobe_i),
        .phase_clear_i               (phase_clear_i),
`ifdef TRIANGLE_MODE_EN
        .mode_i                      (mode_i),
`endif
        .counter_value_o             (counter_value_o),
        .next_counter_value_strobe_o (next_counter_value_strobe_o),
        .wrap_o                      (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int val();
        return int'($signed(counter_value_o));
    endfunction

    // Step edges until a strobe is seen (bounded), then check the number of
    // edges taken, the sample value and the wrap flag.
    task automatic wait_strobe(input string tag, input int exp_val,
                               input int exp_wrap, input int exp_n);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 64) begin
            @(posedge clk_i);
            #1;
            n++;
            if (next_counter_value_strobe_o) seen = 1;
        end
        chk({tag, "_gap"},  n,        exp_n);
        chk({tag, "_val"},  val(),    exp_val);
        chk({tag, "_wrap"}, int'(wrap_o), exp_wrap);
    endtask

    task automatic tick1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cnt;
        rst_i = 1'b1;
        enable_i = 1'b0;
        step_i = '0;
        presc_i = '0;
        cfg_load_strobe_i = 1'b0;
        phase_clear_i = 1'b0;
`ifdef TRIANGLE_MODE_EN
        mode_i = 1'b0;
`endif
        repeat (3) tick1();
        chk("rst_val",    val(), 0);
        chk("rst_strobe", int'(next_counter_value_strobe_o), 0);
        chk("rst_wrap",   int'(wrap_o), 0);
        rst_i = 1'b0;

        // Load config while idle, then enable: sawtooth step 16, period 4.
        tick1();
        step_i = 8'd16; presc_i = 16'd3; cfg_load_strobe_i = 1'b1;
        tick1();
        cfg_load_strobe_i = 1'b0;
        enable_i = 1'b1;
        wait_strobe("saw16", 16, 0, 5);
        wait_strobe("saw32", 32, 0, 4);
        wait_strobe("saw48", 48, 0, 4);

        // Mid-ramp load: pending only, old period until the wrap strobe.
        step_i = 8'd1; presc_i = 16'd0; cfg_load_strobe_i = 1'b1;
        tick1();
        cfg_load_strobe_i = 1'b0;
        wait_strobe("saw64", 64, 0, 3);
        wait_strobe("saw80", 80, 0, 4);
        wait_strobe("saw96", 96, 0, 4);
        wait_strobe("saw112", 112, 0, 4);
        wait_strobe("saw_m128", -128, 1, 4);
        wait_strobe("fast_m127", -127, 0, 1);
        wait_strobe("fast_m126", -126, 0, 1);

        // Clear on a tick cycle (every cycle ticks at presc 0).
        phase_clear_i = 1'b1;
        tick1();
        phase_clear_i = 1'b0;
        chk("clr_val",    val(), 0);
        chk("clr_strobe", int'(next_counter_value_strobe_o), 0);
        wait_strobe("clr_next1", 1, 0, 1);
        wait_strobe("clr_next2", 2, 0, 1);

        // Drop enable on a tick cycle: that tick completes, then hold.
        enable_i = 1'b0;
        tick1();
        chk("drop_strobe", int'(next_counter_value_strobe_o), 1);
        chk("drop_val",    val(), 3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick1();
            if (next_counter_value_strobe_o) cnt++;
        end
        chk("hold_strobes", cnt, 0);
        chk("hold_val",     val(), 3);

        // Re-enable with a coincident load: applied directly.
        enable_i = 1'b1;
        step_i = 8'd16; presc_i = 16'd3; cfg_load_strobe_i = 1'b1;
        tick1();
        cfg_load_strobe_i = 1'b0;
        wait_strobe("reen19", 19, 0, 4);
        wait_strobe("reen35", 35, 0, 4);

        // Clear exactly on the tick cycle with period 4.
        repeat (3) tick1();
        chk("pre_clr_strobe", int'(next_counter_value_strobe_o), 0);
        phase_clear_i = 1'b1;
        tick1();
        phase_clear_i = 1'b0;
        chk("clr4_val",    val(), 0);
        chk("clr4_strobe", int'(next_counter_value_strobe_o), 0);
        wait_strobe("clr4_next", 16, 0, 4);

        // Asynchronous reset between edges while the strobe is high.
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_val",    val(), 0);
        chk("arst_strobe", int'(next_counter_value_strobe_o), 0);
        chk("arst_wrap",   int'(wrap_o), 0);
        tick1();
        rst_i = 1'b0;
        // Back in IDLE with default config (step 1, presc 0).
        wait_strobe("post_rst1", 1, 0, 2);
        wait_strobe("post_rst2", 2, 0, 1);

`ifdef TRIANGLE_MODE_EN
        enable_i = 1'b0;
        repeat (2) tick1();
        phase_clear_i = 1'b1;
        tick1();
        phase_clear_i = 1'b0;
        enable_i = 1'b1;
        mode_i = 1'b1;
        step_i = 8'd100; presc_i = 16'd0; cfg_load_strobe_i = 1'b1;
        tick1();
        cfg_load_strobe_i = 1'b0;
        wait_strobe("tri100",  100, 0, 1);
        wait_strobe("tri127",  127, 0, 1);
        wait_strobe("tri27",    27, 0, 1);
        wait_strobe("tri_m73", -73, 0, 1);
        wait_strobe("tri_m127", -127, 1, 1);
        wait_strobe("tri_m27", -27, 0, 1);
        wait_strobe("tri73",    73, 0, 1);
        wait_strobe("tri127b", 127, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_phase_counter_generator
`default_nettype wire
